layer_addr_sequencer: RTL and testbench

//  Per-layer IFM read-address / OFM write-address sequencer, directly downstream of main_controller.

---
 rtl/cnn_pkg.sv | 27 ++
 rtl/win_counter.sv | 29 ++
 rtl/layer_addr_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_layer_addr_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the layer address sequencer: address width,
// sequencer FSM states and the latched per-layer configuration.
package cnn_pkg;

  localparam int OFM_RAM_SIZE = 2378675;
  localparam int AW           = $clog2(OFM_RAM_SIZE);
  localparam int SA_COLS      = 16;
  localparam int SA_SHIFT     = $clog2(SA_COLS);
  // Wide enough for ceil(2047 / SA_COLS) filter groups.
  localparam int FGW          = 12 - SA_SHIFT;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_e;

  typedef struct packed {
    logic [8:0]    size;
    logic [10:0]   ch;
    logic [1:0]    k;
    logic [10:0]   nf;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] wr_base;
  } layer_cfg_t;

  function automatic logic [FGW-1:0] num_groups(input logic [10:0] nf);
    return FGW'((12'(nf) + 12'(SA_COLS - 1)) >> SA_SHIFT);
  endfunction

endpackage

// File: rtl/win_counter.sv
// One stage of the cascaded window counter: counts 0..max on inc, wraps to 0,
// and flags the wrap so the next stage can advance.
module win_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = inc && (cnt == max);

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values; blocking assignments here would make results order-dependent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == max) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/layer_addr_sequencer.sv
// Per-layer IFM read / OFM write address sequencer (fg -> row -> col -> ch -> ky -> kx).
// Optional SEQ_PERF_CNT_EN adds perf_beats / perf_stalls handshake counters.
module layer_addr_sequencer
  import cnn_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_layer,
  input  logic [8:0]    ifm_size,
  input  logic [10:0]   ifm_channel,
  input  logic [1:0]    kernel_size,
  input  logic [10:0]   num_filter,
  input  logic [AW-1:0] start_read_addr,
  input  logic [AW-1:0] start_write_addr,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW-1:0] rd_addr,
  output logic          rd_last_win,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] wr_plane,
  output logic          busy,
  output logic          done_layer
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]   perf_beats,
  output logic [31:0]   perf_stalls
`endif
);

  seq_state_e     state;
  layer_cfg_t     cfg;
  logic [8:0]     osz;
  logic [AW-1:0]  plane_in;
  logic [FGW-1:0] n_fg;

  logic [1:0]     kx, ky;
  logic [10:0]    ch;
  logic [8:0]     col, row;
  logic [FGW-1:0] fg;
  logic           kx_wrap, ky_wrap, ch_wrap, col_wrap, row_wrap, fg_wrap;

  // Running address offsets, advanced by addition as the counters step.
  logic [AW-1:0]  row_base;  // start_read_addr + row*ifm_size
  logic [AW-1:0]  ky_off;    // ky*ifm_size
  logic [AW-1:0]  ch_off;    // ch*plane_in
  logic [AW-1:0]  orow;      // row*osz
  logic [AW-1:0]  fg_base;   // start_write_addr + fg*SA_COLS*plane_out

  logic          fire, clr, degenerate;
  logic [8:0]    osz_c;

  assign fire       = rd_valid && rd_ready;
  assign clr        = (state == LOAD);
  assign osz_c      = cfg.size - 9'(cfg.k) + 9'd1;
  assign degenerate = (cfg.size == '0) || (cfg.ch == '0) || (cfg.nf == '0) ||
                      (cfg.k == '0) || (9'(cfg.k) > cfg.size);

  win_counter #(.W(2)) u_kx (
    .clk, .rst_n, .clr, .inc(fire),
    .max(cfg.k - 2'd1), .cnt(kx), .wrap(kx_wrap)
  );
  win_counter #(.W(2)) u_ky (
    .clk, .rst_n, .clr, .inc(kx_wrap),
    .max(cfg.k - 2'd1), .cnt(ky), .wrap(ky_wrap)
  );
  win_counter #(.W(11)) u_ch (
    .clk, .rst_n, .clr, .inc(ky_wrap),
    .max(cfg.ch - 11'd1), .cnt(ch), .wrap(ch_wrap)
  );
  win_counter #(.W(9)) u_col (
    .clk, .rst_n, .clr, .inc(ch_wrap),
    .max(osz - 9'd1), .cnt(col), .wrap(col_wrap)
  );
  win_counter #(.W(9)) u_row (
    .clk, .rst_n, .clr, .inc(col_wrap),
    .max(osz - 9'd1), .cnt(row), .wrap(row_wrap)
  );
  win_counter #(.W(FGW)) u_fg (
    .clk, .rst_n, .clr, .inc(row_wrap),
    .max(n_fg - FGW'(1)), .cnt(fg), .wrap(fg_wrap)
  );

  // row and fg only feed their wrap chain; addresses use the running offsets.
  logic unused_cnt;
  assign unused_cnt = &{1'b0, row, fg};

  assign rd_last_win = rd_valid && (kx == cfg.k - 2'd1) && (ky == cfg.k - 2'd1) &&
                       (ch == cfg.ch - 11'd1);
  assign rd_addr     = row_base + ch_off + ky_off + AW'(col) + AW'(kx);
  assign wr_addr     = fg_base + orow + AW'(col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cfg        <= '0;
      osz        <= '0;
      plane_in   <= '0;
      wr_plane   <= '0;
      n_fg       <= '0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
      done_layer <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_layer) begin
            cfg   <= '{size: ifm_size, ch: ifm_channel, k: kernel_size, nf: num_filter,
                       rd_base: start_read_addr, wr_base: start_write_addr};
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          osz      <= osz_c;
          plane_in <= AW'(cfg.size) * AW'(cfg.size);
          wr_plane <= AW'(osz_c) * AW'(osz_c);
          n_fg     <= num_groups(cfg.nf);
          if (degenerate) begin
            done_layer <= 1'b1;
            state      <= DONE;
          end else begin
            rd_valid <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // One idle cycle after the final handshake before done_layer rises.
          if (!rd_valid) begin
            done_layer <= 1'b1;
            state      <= DONE;
          end else if (fg_wrap) begin
            rd_valid <= 1'b0;
          end
        end
        DONE: begin
          done_layer <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base <= '0;
      ky_off   <= '0;
      ch_off   <= '0;
      orow     <= '0;
      fg_base  <= '0;
    end else if (clr) begin
      row_base <= cfg.rd_base;
      ky_off   <= '0;
      ch_off   <= '0;
      orow     <= '0;
      fg_base  <= cfg.wr_base;
    end else if (fire) begin
      if (ky_wrap)       ky_off <= '0;
      else if (kx_wrap)  ky_off <= ky_off + AW'(cfg.size);
      if (ch_wrap)       ch_off <= '0;
      else if (ky_wrap)  ch_off <= ch_off + plane_in;
      if (row_wrap)      row_base <= cfg.rd_base;
      else if (col_wrap) row_base <= row_base + AW'(cfg.size);
      if (row_wrap)      orow <= '0;
      else if (col_wrap) orow <= orow + AW'(osz);
      if (row_wrap)      fg_base <= fg_base + (wr_plane << SA_SHIFT);
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats  <= '0;
      perf_stalls <= '0;
    end else if (state == IDLE && start_layer) begin
      perf_beats  <= '0;
      perf_stalls <= '0;
    end else begin
      if (fire)                   perf_beats  <= perf_beats + 32'd1;
      if (rd_valid && !rd_ready)  perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_layer_addr_sequencer.sv
// Self-checking bench for layer_addr_sequencer: directed layers plus random
// configs and random rd_ready, checked against a nested-loop address model.
module tb_layer_addr_sequencer;

  localparam int AW  = 22;
  localparam int SAC = 16;
  localparam int unsigned AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_layer;
  logic [8:0]    ifm_size;
  logic [10:0]   ifm_channel;
  logic [1:0]    kernel_size;
  logic [10:0]   num_filter;
  logic [AW-1:0] start_read_addr;
  logic [AW-1:0] start_write_addr;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_last_win;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] wr_plane;
  logic          busy;
  logic          done_layer;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned rd;
    bit          last;
    int unsigned wr;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  layer_addr_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_layer      (start_layer),
    .ifm_size         (ifm_size),
    .ifm_channel      (ifm_channel),
    .kernel_size      (kernel_size),
    .num_filter       (num_filter),
    .start_read_addr  (start_read_addr),
    .start_write_addr (start_write_addr),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_addr          (rd_addr),
    .rd_last_win      (rd_last_win),
    .wr_addr          (wr_addr),
    .wr_plane         (wr_plane),
    .busy             (busy),
    .done_layer       (done_layer)
  );

  // Expected beat list straight from the convolution definition.
  task automatic build_model(input int sz, input int ch, input int k, input int nf,
                             input int unsigned rdb, input int unsigned wrb);
    int osz, nfg;
    beat_t b;
    exp_q.delete();
    if (sz == 0 || ch == 0 || nf == 0 || k == 0 || k > sz) return;
    osz = sz - k + 1;
    nfg = (nf + SAC - 1) / SAC;
    for (int g = 0; g < nfg; g++)
      for (int r = 0; r < osz; r++)
        for (int c = 0; c < osz; c++)
          for (int h = 0; h < ch; h++)
            for (int y = 0; y < k; y++)
              for (int x = 0; x < k; x++) begin
                b.rd   = (rdb + h*sz*sz + (r+y)*sz + c + x) & AMASK;
                b.last = (h == ch-1) && (y == k-1) && (x == k-1);
                b.wr   = (wrb + g*SAC*osz*osz + r*osz + c) & AMASK;
                exp_q.push_back(b);
              end
  endtask

  task automatic run_layer(input string name, input int sz, input int ch, input int k,
                           input int nf, input int unsigned rdb, input int unsigned wrb,
                           input int pct, input int glitch, output int done_cyc);
    int cyc, last_hs, nbeats, budget, exp_done, osz;
    bit seen_valid;
    build_model(sz, ch, k, nf, rdb, wrb);
    nbeats     = exp_q.size();
    osz        = sz - k + 1;
    budget     = 40 * nbeats + 40;
    seen_valid = 1'b0;
    last_hs    = -1;
    done_cyc   = -1;
    @(posedge clk); #1;
    ifm_size         = 9'(sz);
    ifm_channel      = 11'(ch);
    kernel_size      = 2'(k);
    num_filter       = 11'(nf);
    start_read_addr  = AW'(rdb);
    start_write_addr = AW'(wrb);
    start_layer      = 1'b1;
    rd_ready         = 1'b0;
    cyc = 0;
    while (cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      // Config pins are free to change once latched; a stray start must be ignored.
      start_layer      = (cyc == glitch);
      ifm_size         = 9'($urandom);
      ifm_channel      = 11'($urandom);
      kernel_size      = 2'($urandom);
      num_filter       = 11'($urandom);
      start_read_addr  = AW'($urandom);
      start_write_addr = AW'($urandom);
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1 || rd_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s load_cycle: busy=%b rd_valid=%b expected busy=1 rd_valid=0",
                   name, busy, rd_valid);
        end
      end
      if (rd_valid === 1'b1) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          checks += 2;
          if (cyc != 2) begin
            failures++;
            $display("FAIL %s first_valid_cycle: got %0d expected 2", name, cyc);
          end
          if (wr_plane !== AW'(osz*osz)) begin
            failures++;
            $display("FAIL %s wr_plane: got %0d expected %0d", name, wr_plane, osz*osz);
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_beat: rd_addr=%0d at cycle %0d", name, rd_addr, cyc);
          break;
        end
        checks += 3;
        if (rd_addr !== AW'(exp_q[0].rd)) begin
          failures++;
          $display("FAIL %s rd_addr beat %0d: got %0d expected %0d", name,
                   nbeats - exp_q.size(), rd_addr, exp_q[0].rd);
        end
        if (rd_last_win !== exp_q[0].last) begin
          failures++;
          $display("FAIL %s rd_last_win beat %0d: got %b expected %b", name,
                   nbeats - exp_q.size(), rd_last_win, exp_q[0].last);
        end
        if (wr_addr !== AW'(exp_q[0].wr)) begin
          failures++;
          $display("FAIL %s wr_addr beat %0d: got %0d expected %0d", name,
                   nbeats - exp_q.size(), wr_addr, exp_q[0].wr);
        end
        rd_ready = ($urandom_range(0, 99) < pct);
        if (rd_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) last_hs = cyc;
        end
      end else begin
        rd_ready = 1'($urandom_range(0, 1));
      end
      if (done_layer === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    start_layer = 1'b0;
    rd_ready    = 1'b0;
    checks++;
    if (done_cyc < 0) begin
      failures++;
      $display("FAIL %s done_timeout: no done_layer within %0d cycles", name, budget);
      return;
    end
    exp_done = (nbeats == 0) ? 2 : last_hs + 2;
    checks += 3;
    if (done_cyc != exp_done) begin
      failures++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
    end
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s beats_missing: got %0d expected %0d", name,
               nbeats - exp_q.size(), nbeats);
    end
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_at_done: got %b expected 1", name, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done_layer !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: done=%b busy=%b rd_valid=%b expected 0 0 0",
               name, done_layer, busy, rd_valid);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (rd_valid !== 1'b0 || rd_addr !== '0 || rd_last_win !== 1'b0 || wr_addr !== '0 ||
        wr_plane !== '0 || busy !== 1'b0 || done_layer !== 1'b0) begin
      failures++;
      $display("FAIL %s outputs_zero: v=%b ra=%0d lw=%b wa=%0d wp=%0d busy=%b done=%b expected all 0",
               name, rd_valid, rd_addr, rd_last_win, wr_addr, wr_plane, busy, done_layer);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_t1();
    int d;
    run_layer("t1", 2, 1, 1, 4, 100, 500, 100, 0, d);
    checks++;
    if (d != 7) begin
      failures++;
      $display("FAIL t1 done_cycle_abs: got %0d expected 7", d);
    end
  endtask

  task automatic test_t2_t3_t4();
    int d;
    run_layer("t2", 4, 2, 3, SAC, 0, 0, 100, 0, d);
    run_layer("t3", 4, 2, 3, SAC, 0, 0, 50, 0, d);
    run_layer("t4", 3, 1, 3, SAC + 1, 0, 0, 100, 0, d);
  endtask

  task automatic test_degenerate();
    int d;
    run_layer("t5_k_gt_ifm", 2, 1, 3, 4, 7, 9, 100, 0, d);
    run_layer("degen_nf0", 4, 2, 1, 0, 7, 9, 100, 0, d);
    run_layer("degen_ch0", 4, 0, 1, 3, 7, 9, 100, 0, d);
  endtask

  task automatic test_reset_mid_run();
    int d;
    @(posedge clk); #1;
    ifm_size = 9'd4; ifm_channel = 11'd2; kernel_size = 2'd3; num_filter = 11'(SAC);
    start_read_addr = AW'(33); start_write_addr = AW'(44);
    start_layer = 1'b1;
    rd_ready    = 1'b1;
    @(posedge clk); #1;
    start_layer = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset_mid_run");
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) rst_n = 1'b1;
      checks++;
      if (done_layer !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL t6_no_done: done=%b rd_valid=%b busy=%b expected 0 0 0",
                 done_layer, rd_valid, busy);
      end
    end
    run_layer("t6_restart", 4, 2, 3, SAC, 0, 0, 100, 10, d);
  endtask

  task automatic test_random();
    int d, sz, k;
    for (int n = 0; n < 6; n++) begin
      sz = $urandom_range(1, 6);
      k  = ($urandom_range(0, 3) == 0) ? 1 : 3;
      run_layer($sformatf("rand%0d", n), sz, $urandom_range(1, 3), k,
                $urandom_range(1, 40), $urandom_range(0, 50000), $urandom_range(0, 50000),
                $urandom_range(40, 100), $urandom_range(3, 12), d);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    start_layer      = 1'b0;
    rd_ready         = 1'b0;
    ifm_size         = '0;
    ifm_channel      = '0;
    kernel_size      = '0;
    num_filter       = '0;
    start_read_addr  = '0;
    start_write_addr = '0;
    test_reset();
    test_t1();
    test_t2_t3_t4();
    test_degenerate();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
